// File: rtl/fpga_led_pio_pkg.sv
// ----------------------------------------------------------------------------
// fpga_led_pio_pkg
//   Shared definitions for the LED output PIO:
//   - word addresses of the register map (ADDR_DATA .. ADDR_STATUS)
//   - write-operation enum for the four DATA-family addresses
//   - decode_op(): maps a DATA-family address to its write operation
//   - apply_op():  applies a write operation to a 32-bit image of DATA
// ----------------------------------------------------------------------------
package fpga_led_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_SET     = 3'd1;
  localparam logic [2:0] ADDR_CLEAR   = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE  = 3'd3;
  localparam logic [2:0] ADDR_BMASK   = 3'd4;
  localparam logic [2:0] ADDR_BPERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2,
    OP_TGL  = 2'd3
  } wr_op_e;

  // Only meaningful for addresses 0..3; the low two address bits select the op.
  function automatic wr_op_e decode_op(input logic [2:0] addr);
    wr_op_e op;
    case (addr[1:0])
      2'd0:    op = OP_LOAD;
      2'd1:    op = OP_SET;
      2'd2:    op = OP_CLR;
      default: op = OP_TGL;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] apply_op(input wr_op_e op,
                                           input logic [31:0] cur,
                                           input logic [31:0] wd);
    logic [31:0] res;
    case (op)
      OP_LOAD: res = wd;
      OP_SET:  res = cur | wd;
      OP_CLR:  res = cur & ~wd;
      default: res = cur ^ wd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// ----------------------------------------------------------------------------
// led_blink_timer
//   Free-running half-period counter that produces the blink phase.
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous active-high reset (cnt_q = 0, phase_q = 1)
//     period     in   CNT_W  half-period in clk cycles; 0 stops blinking
//     period_wr  in   restart strobe (period register being written this edge)
//     cnt_q      out  CNT_W  current counter value
//     phase_q    out  current phase (1 = blinking channels on)
//     phase_next out  phase that will be registered at the coming edge
// ----------------------------------------------------------------------------
module led_blink_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic             period_wr,
  output logic [CNT_W-1:0] cnt_q,
  output logic             phase_q,
  output logic             phase_next
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             phase_reg;
  logic             phase_nxt;

  // A period write restarts the cadence from the "on" phase, which also
  // keeps a shortened period from being overrun by a larger running count.
  always_comb begin
    cnt_next  = cnt_reg + ONE;
    phase_nxt = phase_reg;
    if (period_wr || (period == '0)) begin
      cnt_next  = '0;
      phase_nxt = 1'b1;
    end else if (cnt_reg == (period - ONE)) begin
      cnt_next  = '0;
      phase_nxt = ~phase_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_nxt;
    end
  end

  assign cnt_q      = cnt_reg;
  assign phase_q    = phase_reg;
  assign phase_next = phase_nxt;

endmodule

// File: rtl/fpga_system_led_pio_ctrl.sv
// ----------------------------------------------------------------------------
// fpga_system_led_pio_ctrl
//   Avalon-MM slave output PIO for board LEDs with atomic SET/CLEAR/TOGGLE
//   writes and an optional per-channel blink engine.
//   Optional feature macro: LED_PIO_BLINK_EN (blink engine, addresses 4..6).
//   Ports:
//     clk         in   system clock
//     reset       in   synchronous active-high reset
//     address     in   3      word address
//     chipselect  in   slave select
//     write_n     in   active-low write strobe
//     writedata   in   32     write data (bits above WIDTH/CNT_W ignored)
//     readdata    out  32     combinational read data, zero-extended
//     out_port    out  WIDTH  registered LED drive
// ----------------------------------------------------------------------------
module fpga_system_led_pio_ctrl
  import fpga_led_pio_pkg::*;
#(
  parameter int               WIDTH     = 18,
  parameter int               CNT_W     = 26,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic             data_wr;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;
  logic [31:0]      cur_word;
  logic [31:0]      op_result;
  logic             unused_op_bits;

  assign wr_en   = chipselect & ~write_n;
  assign data_wr = wr_en & ~address[2];

  always_comb begin
    cur_word              = '0;
    cur_word[WIDTH-1:0]   = data_reg;
    op_result             = apply_op(decode_op(address), cur_word, writedata);
    data_next             = data_reg;
    if (data_wr) begin
      data_next = op_result[WIDTH-1:0];
    end
  end

  assign unused_op_bits = ^op_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RESET_VAL;
      out_reg  <= RESET_VAL;
    end else begin
      data_reg <= data_next;
      out_reg  <= out_next;
    end
  end

  assign out_port = out_reg;

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0] bmask_reg;
  logic [CNT_W-1:0] bperiod_reg;
  logic             bperiod_wr;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;
  logic             phase_next;
  logic [CNT_W:0]   status_word;

  assign bperiod_wr = wr_en & (address == ADDR_BPERIOD);

  always_ff @(posedge clk) begin
    if (reset) begin
      bmask_reg   <= '0;
      bperiod_reg <= '0;
    end else begin
      if (wr_en && (address == ADDR_BMASK)) begin
        bmask_reg <= writedata[WIDTH-1:0];
      end
      if (bperiod_wr) begin
        bperiod_reg <= writedata[CNT_W-1:0];
      end
    end
  end

  led_blink_timer #(
    .CNT_W(CNT_W)
  ) u_blink_timer (
    .clk       (clk),
    .reset     (reset),
    .period    (bperiod_reg),
    .period_wr (bperiod_wr),
    .cnt_q     (cnt_q),
    .phase_q   (phase_q),
    .phase_next(phase_next)
  );

  // Blinking channels are dark while the upcoming phase is 0; the gate uses
  // the mask currently in force so a mask write shows one edge later.
  assign out_next    = data_next & ~(bmask_reg & {WIDTH{~phase_next}});
  assign status_word = {cnt_q, phase_q};

  always_comb begin
    case (address)
      ADDR_DATA:    readdata = 32'(data_reg);
      ADDR_BMASK:   readdata = 32'(bmask_reg);
      ADDR_BPERIOD: readdata = 32'(bperiod_reg);
      ADDR_STATUS:  readdata = 32'(status_word);
      default:      readdata = '0;
    endcase
  end
`else
  assign out_next = data_next;

  always_comb begin
    case (address)
      ADDR_DATA: readdata = 32'(data_reg);
      default:   readdata = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_fpga_system_led_pio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fpga_system_led_pio_ctrl
//   Directed stimulus with literal expectations, plus a cycle-level model of
//   the register map that is compared against the DUT on every falling edge.
//   The blink phase in the model is derived from the number of edges since the
//   last restart rather than from a counter/toggle pair.
// ----------------------------------------------------------------------------
module tb_fpga_system_led_pio_ctrl;

  localparam int          W     = 18;
  localparam int          CW    = 26;
  localparam logic [17:0] RV    = 18'h00F0;
  localparam longint      DMASK = (longint'(1) << W) - 1;
  localparam longint      CMASK = (longint'(1) << CW) - 1;
`ifdef LED_PIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] out_port;

  int checks   = 0;
  int failures = 0;

  fpga_system_led_pio_ctrl #(
    .WIDTH    (W),
    .CNT_W    (CW),
    .RESET_VAL(RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_data, m_bmask, m_period, m_elapsed, m_out;
  bit     m_valid = 1'b0;

  function automatic bit m_phase();
    if (m_period == 0) return 1'b1;
    return ((m_elapsed / m_period) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    longint cnt;
    cnt = (m_period == 0) ? 0 : (m_elapsed % m_period);
    case (a)
      3'd0:    return 32'(m_data);
      3'd4:    return BLINK ? 32'(m_bmask) : 32'd0;
      3'd5:    return BLINK ? 32'(m_period) : 32'd0;
      3'd6:    return BLINK ? 32'((cnt << 1) | longint'(m_phase())) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    longint nd, wd, old_mask;
    bit     wr;
    if (reset) begin
      m_data    = longint'(RV);
      m_bmask   = 0;
      m_period  = 0;
      m_elapsed = 0;
      m_out     = longint'(RV);
      m_valid   = 1'b1;
    end else if (m_valid) begin
      wr       = chipselect && !write_n;
      wd       = longint'(writedata);
      nd       = m_data;
      old_mask = m_bmask;
      if (wr) begin
        case (address)
          3'd0: nd = wd & DMASK;
          3'd1: nd = (m_data | wd) & DMASK;
          3'd2: nd = m_data & ~wd & DMASK;
          3'd3: nd = (m_data ^ wd) & DMASK;
          default: ;
        endcase
      end
      if (BLINK) begin
        if (wr && address == 3'd4) m_bmask = wd & DMASK;
        if (wr && address == 3'd5) begin
          m_period  = wd & CMASK;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      m_data = nd;
      m_out  = (BLINK && !m_phase()) ? (nd & ~old_mask) : nd;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out_port", 32'(out_port), 32'(m_out));
      chk("model_readdata", readdata, m_read(address));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    $display("WR addr=%0d data=0x%08h t=%0t", a, d, $time);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #2;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    $display("RD addr=%0d data=0x%08h t=%0t", a, readdata, $time);
    chk(name, readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    idle(3);

    // Reset state
    rd_chk(3'd0, 32'h0000_00F0, "reset_data");
    chk("reset_out", 32'(out_port), 32'h0000_00F0);
    reset = 1'b0;

    // DATA / SET / CLEAR / TOGGLE
    bus_write(3'd0, 32'hFFFF_FFFF);
    rd_chk(3'd0, 32'h0003_FFFF, "data_load_trunc");
    chk("out_load", 32'(out_port), 32'h0003_FFFF);
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'h1);
    rd_chk(3'd0, 32'h0000_0001, "data_set");
    chk("out_set", 32'(out_port), 32'h1);
    bus_write(3'd2, 32'hF);
    rd_chk(3'd0, 32'h0, "data_clear");
    chk("out_clear", 32'(out_port), 32'h0);
    bus_write(3'd3, 32'h11);
    rd_chk(3'd0, 32'h11, "data_toggle");
    chk("out_toggle", 32'(out_port), 32'h11);

    // Write-only and unused addresses read zero; address 7 ignores writes
    rd_chk(3'd1, 32'h0, "read_set_zero");
    rd_chk(3'd2, 32'h0, "read_clear_zero");
    rd_chk(3'd3, 32'h0, "read_toggle_zero");
    bus_write(3'd7, 32'hFFFF_FFFF);
    rd_chk(3'd7, 32'h0, "read_addr7_zero");
    rd_chk(3'd0, 32'h11, "addr7_write_ignored");

`ifdef LED_PIO_BLINK_EN
    bus_write(3'd0, 32'h3);
    bus_write(3'd4, 32'h1);
    bus_write(3'd5, 32'd4);
    for (int i = 0; i < 16; i++) begin
      chk("blink4_bit0", 32'(out_port[0]), 32'(((i / 4) % 2) == 0));
      chk("blink4_bit1", 32'(out_port[1]), 32'h1);
      idle(1);
    end
    rd_chk(3'd6, 32'h1, "status_wrap");
    idle(3);
    rd_chk(3'd6, 32'h7, "status_cnt3");
    bus_write(3'd5, 32'd2);
    rd_chk(3'd6, 32'h1, "status_restart");
    for (int i = 0; i < 6; i++) begin
      chk("blink2_bit0", 32'(out_port[0]), 32'(((i / 2) % 2) == 0));
      idle(1);
    end
    bus_write(3'd5, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stopped_bit0", 32'(out_port[0]), 32'h1);
      idle(1);
    end
    rd_chk(3'd6, 32'h1, "status_stopped");
    bus_write(3'd5, 32'd2);
    idle(2);
    chk("phase0_bit0", 32'(out_port[0]), 32'h0);
    rd_chk(3'd6, 32'h0, "status_phase0");
`else
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    rd_chk(3'd4, 32'h0, "nob_bmask_zero");
    rd_chk(3'd5, 32'h0, "nob_bperiod_zero");
    rd_chk(3'd6, 32'h0, "nob_status_zero");
    idle(5);
    chk("nob_out_eq_data", 32'(out_port), 32'h11);
`endif

    // Reset in the middle of activity
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midreset_out", 32'(out_port), 32'h0000_00F0);
    rd_chk(3'd6, BLINK ? 32'h1 : 32'h0, "midreset_status");
    rd_chk(3'd0, 32'h0000_00F0, "midreset_data");
    rd_chk(3'd4, 32'h0, "midreset_bmask");
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
